pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline register for the 16-bit core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a control bundle, N data words and M register tags with a valid/ready handshake.
//  Optional 2-entry skid buffer, synchronous flush, NOP (bubble) injection and a bubble counter.
//  Supersedes the fixed-width always-enabled stage registers; stalls are now first-class.
// PARAMETERS
//  CTRL_W    10  control bundle width (e.g. EX 5 + MEM 1 + WB 4)
//  DATA_W    16  width of each data word
//  NUM_DATA  2   number of data words
//  REG_W     4   width of each register tag
//  NUM_REG   4   number of register tags (src1, src2, dst, ll/lh byte sel)
//  SKID      1   1 = 2-entry skid buffer (registered in_ready); 0 = single slot
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  synchronous reset, active-low
//  in_valid   in   1                  upstream beat valid
//  in_ready   out  1                  stage can accept a beat
//  in_nop     in   1                  accepted beat is replaced by a bubble
//  in_ctrl    in   CTRL_W             control bundle
//  in_data    in   NUM_DATA*DATA_W    data words, word 0 in LSBs
//  in_regs    in   NUM_REG*REG_W      register tags, tag 0 in LSBs
//  flush      in   1                  discard all held and incoming beats
//  out_valid  out  1                  downstream beat valid
//  out_ready  in   1                  downstream accepts
//  out_nop    out  1                  current output beat is a bubble
//  out_ctrl   out  CTRL_W
//  out_data   out  NUM_DATA*DATA_W
//  out_regs   out  NUM_REG*REG_W
//  bubble_cnt out  16                 bubbles delivered downstream, saturating
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all entries cleared; out_valid=0, out_nop=0, out_ctrl/data/regs=0,
//    bubble_cnt=0; in_ready=0 while rst low, 1 from the first cycle after release.
//  - Accept: in_valid&&in_ready at posedge. Deliver: out_valid&&out_ready at posedge.
//  - Bubble: accepted beat with in_nop=1 stores ctrl/data/regs all zero, nop flag=1; it still
//    occupies a slot and is delivered with out_valid=1, out_nop=1 (zero control = no side effects).
//  - Outputs are driven directly from the head slot registers; no combinational in->out path.
//  - Latency: empty stage, beat accepted in cycle N -> out_valid in cycle N+1.
//  - Order is strictly FIFO; no beat dropped or duplicated except by flush.
//  - SKID=1 states (occupancy): EMPTY, ONE, TWO.
//      EMPTY: accept->ONE.  ONE: accept&!deliver->TWO; deliver&!accept->EMPTY; both->ONE.
//      TWO: deliver->ONE (skid moves to head); no accept possible.
//      in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. Full throughput with out_ready=1.
//  - SKID=0: single slot; in_ready = rst & (!out_valid | out_ready) (combinational on out_ready).
//  - flush=1 at posedge: all slots invalidated -> EMPTY, out_valid=0 next cycle; a simultaneous
//    accept is dropped; a simultaneous deliver completes; bubble_cnt still counts that deliver.
//  - Reset dominates flush; flush dominates accept.
//  - bubble_cnt += 1 on each deliver with out_nop=1; holds at 16'hFFFF.
//  - Held slot contents stable while out_valid&&!out_ready (protocol: no change until taken).
// STRUCTURE
//  - Package pipe_pkg: CTRL_EX_W=5, CTRL_MEM_W=1, CTRL_WB_W=4, default widths, occupancy
//    state localparams (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
//  - Sub-module pipe_slot: one entry {valid, nop, ctrl, data, regs} with load/clear enables,
//    sync active-low reset; instantiated once (SKID=0) or twice (SKID=1) via generate.
//  - Top: occupancy FSM, slot steering, in_ready register, bubble counter.
// TESTING
//  1 Reset: hold rst=0 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, bubble_cnt=0;
//    after release in_ready=1 next cycle.
//  2 Stream: out_ready=1, 8 beats in_data={16'h0001..16'h0008}, back-to-back -> identical
//    sequence on out_data, 1-cycle latency, no gaps, in_ready stays 1.
//  3 Backpressure (SKID=1): out_ready=0 after beat A=16'hAAAA, send B=16'hBBBB -> state TWO,
//    in_ready=0 next cycle; C held upstream; release -> A,B,C in order, nothing lost.
//  4 Bubble: beat with in_nop=1, in_ctrl=10'h3FF, data 16'hFFFF -> out_nop=1, out_ctrl=0,
//    out_data=0; bubble_cnt 0->1 on delivery only.
//  5 Flush: TWO occupancy plus incoming beat, flush=1 with out_ready=1 -> head delivered once,
//    out_valid=0 next cycle, incoming beat never appears; in_ready=1.
//  6 Saturation / SKID=0: preload bubble_cnt to 16'hFFFE via 3 bubble beats from forced value
//    -> holds 16'hFFFF; SKID=0 build repeats scenarios 2-5 with combinational in_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, occupancy encoding and helpers for pipeline stage buffers
package pipe_pkg;

  localparam int CTRL_EX_W  = 5;
  localparam int CTRL_MEM_W = 1;
  localparam int CTRL_WB_W  = 4;

  localparam int CTRL_W_DEF   = CTRL_EX_W + CTRL_MEM_W + CTRL_WB_W;
  localparam int DATA_W_DEF   = 16;
  localparam int NUM_DATA_DEF = 2;
  localparam int REG_W_DEF    = 4;
  localparam int NUM_REG_DEF  = 4;

  typedef logic [1:0] occ_t;

  localparam occ_t EMPTY = 2'd0;
  localparam occ_t ONE   = 2'd1;
  localparam occ_t TWO   = 2'd2;

  localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == BUBBLE_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one stage-buffer entry holding valid, nop flag, control, data and tags
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_DATA = NUM_DATA_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int NUM_REG  = NUM_REG_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         clear,
  input  logic                         ld_valid,
  input  logic                         ld_nop,
  input  logic [CTRL_W-1:0]            ld_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0]   ld_data,
  input  logic [NUM_REG*REG_W-1:0]     ld_regs,
  output logic                         valid,
  output logic                         nop,
  output logic [CTRL_W-1:0]            ctrl,
  output logic [NUM_DATA*DATA_W-1:0]   data,
  output logic [NUM_REG*REG_W-1:0]     regs
);

  // Load wins over clear so a slot being vacated can be refilled in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      nop   <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
      regs  <= '0;
    end else if (load) begin
      valid <= ld_valid;
      nop   <= ld_nop;
      ctrl  <= ld_nop ? '0 : ld_ctrl;
      data  <= ld_nop ? '0 : ld_data;
      regs  <= ld_nop ? '0 : ld_regs;
    end else if (clear) begin
      valid <= 1'b0;
      nop   <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
      regs  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready inter-stage register with optional skid slot, flush and bubbles
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_DATA = NUM_DATA_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int NUM_REG  = NUM_REG_DEF,
  parameter int SKID     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_nop,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic [NUM_REG*REG_W-1:0]     in_regs,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_nop,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [NUM_REG*REG_W-1:0]     out_regs,
  output logic [15:0]                  bubble_cnt
);

  localparam int DW = NUM_DATA * DATA_W;
  localparam int RW = NUM_REG * REG_W;

  logic              head_valid, head_nop;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DW-1:0]     head_data;
  logic [RW-1:0]     head_regs;

  logic              skid_valid, skid_nop;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DW-1:0]     skid_data;
  logic [RW-1:0]     skid_regs;

  logic              hd_ld_valid, hd_ld_nop;
  logic [CTRL_W-1:0] hd_ld_ctrl;
  logic [DW-1:0]     hd_ld_data;
  logic [RW-1:0]     hd_ld_regs;

  occ_t        occ, occ_nxt;
  logic        accept, deliver;
  logic        head_load, head_from_skid, head_clear;
  logic        skid_load, skid_clear;
  logic [15:0] bubble_cnt_q;

  assign accept  = in_valid & in_ready;
  assign deliver = head_valid & out_ready;

  assign out_valid  = head_valid;
  assign out_nop    = head_nop;
  assign out_ctrl   = head_ctrl;
  assign out_data   = head_data;
  assign out_regs   = head_regs;
  assign bubble_cnt = bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) occ <= EMPTY;
    else      occ <= occ_nxt;
  end

  always_comb begin
    occ_nxt = occ;
    if (flush) begin
      occ_nxt = EMPTY;
    end else begin
      case (occ)
        EMPTY:   if (accept) occ_nxt = ONE;
        ONE: begin
          if (accept && !deliver)      occ_nxt = TWO;
          else if (deliver && !accept) occ_nxt = EMPTY;
        end
        TWO:     if (deliver) occ_nxt = ONE;
        default: occ_nxt = EMPTY;
      endcase
    end
  end

  // A deliver during flush still completes on the wire; the slots are simply emptied behind it.
  always_comb begin
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    head_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (occ)
        EMPTY: head_load = accept;
        ONE: begin
          if (accept && deliver) head_load  = 1'b1;
          else if (accept)       skid_load  = 1'b1;
          else if (deliver)      head_clear = 1'b1;
        end
        TWO: begin
          if (deliver) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign hd_ld_valid = head_from_skid ? skid_valid : 1'b1;
  assign hd_ld_nop   = head_from_skid ? skid_nop   : in_nop;
  assign hd_ld_ctrl  = head_from_skid ? skid_ctrl  : in_ctrl;
  assign hd_ld_data  = head_from_skid ? skid_data  : in_data;
  assign hd_ld_regs  = head_from_skid ? skid_regs  : in_regs;

  pipe_slot #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .REG_W(REG_W), .NUM_REG(NUM_REG)
  ) u_head (
    .clk(clk), .rst(rst), .load(head_load), .clear(head_clear),
    .ld_valid(hd_ld_valid), .ld_nop(hd_ld_nop), .ld_ctrl(hd_ld_ctrl),
    .ld_data(hd_ld_data), .ld_regs(hd_ld_regs),
    .valid(head_valid), .nop(head_nop), .ctrl(head_ctrl), .data(head_data), .regs(head_regs)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;

      pipe_slot #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .REG_W(REG_W), .NUM_REG(NUM_REG)
      ) u_skid (
        .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clear),
        .ld_valid(1'b1), .ld_nop(in_nop), .ld_ctrl(in_ctrl),
        .ld_data(in_data), .ld_regs(in_regs),
        .valid(skid_valid), .nop(skid_nop), .ctrl(skid_ctrl), .data(skid_data), .regs(skid_regs)
      );

      // Registered ready breaks the out_ready -> in_ready timing path; the skid slot absorbs the lag.
      always_ff @(posedge clk) begin
        if (!rst) ready_q <= 1'b0;
        else      ready_q <= (occ_nxt != TWO);
      end
      assign in_ready = ready_q;
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_nop   = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign skid_regs  = '0;
      assign in_ready   = rst & (!head_valid | out_ready);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst)                      bubble_cnt_q <= 16'd0;
    else if (deliver && head_nop)  bubble_cnt_q <= sat_inc(bubble_cnt_q);
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for SKID=1 and SKID=0 builds
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_nop;
  logic [9:0]  in_ctrl;
  logic [31:0] in_data;
  logic [15:0] in_regs;

  logic        v1, r1, fl1, ordy1, ov1, on1;
  logic [9:0]  oc1;
  logic [31:0] od1;
  logic [15:0] og1, bc1;

  logic        v0, r0, fl0, ordy0, ov0, on0;
  logic [9:0]  oc0;
  logic [31:0] od0;
  logic [15:0] og0, bc0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.SKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_nop(in_nop),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs), .flush(fl1),
    .out_valid(ov1), .out_ready(ordy1), .out_nop(on1), .out_ctrl(oc1),
    .out_data(od1), .out_regs(og1), .bubble_cnt(bc1)
  );

  pipe_stage_buf #(.SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_nop(in_nop),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs), .flush(fl0),
    .out_valid(ov0), .out_ready(ordy0), .out_nop(on0), .out_ctrl(oc0),
    .out_data(od0), .out_regs(og0), .bubble_cnt(bc0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] w0, input logic nop);
    in_nop  = nop;
    in_ctrl = 10'h155;
    in_data = {w0 ^ 16'h5A5A, w0};
    in_regs = w0 ^ 16'hC3C3;
  endtask

  initial begin
    rst = 1'b0; in_nop = 1'b0; in_ctrl = '0; in_data = '0; in_regs = '0;
    v1 = 1'b1; fl1 = 1'b0; ordy1 = 1'b0;
    v0 = 1'b1; fl0 = 1'b0; ordy0 = 1'b0;

    // Reset held three cycles with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ov1", ov1, 0); chk("rst_r1", r1, 0); chk("rst_bc1", bc1, 0);
      chk("rst_ov0", ov0, 0); chk("rst_r0", r0, 0); chk("rst_bc0", bc0, 0);
    end
    rst = 1'b1; v1 = 1'b0; v0 = 1'b0;
    tick();
    chk("rel_r1", r1, 1); chk("rel_r0", r0, 1); chk("rel_ov1", ov1, 0);

    // SKID=1 stream of 8 back-to-back beats
    ordy1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(16'(i + 1), 1'b0); v1 = 1'b1;
      tick();
      chk("s1_str_ov", ov1, 1);
      chk("s1_str_od", od1, {16'(i + 1) ^ 16'h5A5A, 16'(i + 1)});
      chk("s1_str_og", og1, 16'(i + 1) ^ 16'hC3C3);
      chk("s1_str_oc", oc1, 10'h155);
      chk("s1_str_r", r1, 1);
    end
    v1 = 1'b0;
    tick();
    chk("s1_str_end", ov1, 0);

    // SKID=1 backpressure: A, B fill both slots, C waits upstream
    ordy1 = 1'b0;
    beat(16'hAAAA, 1'b0); v1 = 1'b1;
    tick();
    chk("s1_bp_a", od1[15:0], 16'hAAAA); chk("s1_bp_r_one", r1, 1);
    beat(16'hBBBB, 1'b0);
    tick();
    chk("s1_bp_r_two", r1, 0); chk("s1_bp_hold_a", od1[15:0], 16'hAAAA);
    beat(16'hCCCC, 1'b0);
    tick();
    chk("s1_bp_stable", od1[15:0], 16'hAAAA); chk("s1_bp_r_still", r1, 0);
    ordy1 = 1'b1;
    tick();
    chk("s1_bp_b", od1[15:0], 16'hBBBB); chk("s1_bp_r_back", r1, 1);
    tick();
    chk("s1_bp_c", od1[15:0], 16'hCCCC); chk("s1_bp_c_v", ov1, 1);
    v1 = 1'b0;
    tick();
    chk("s1_bp_empty", ov1, 0);

    // SKID=1 bubble counted on delivery only
    ordy1 = 1'b0;
    v1 = 1'b1; in_nop = 1'b1; in_ctrl = 10'h3FF; in_data = 32'hFFFF_FFFF; in_regs = 16'hFFFF;
    tick();
    v1 = 1'b0; in_nop = 1'b0;
    chk("s1_bub_ov", ov1, 1); chk("s1_bub_nop", on1, 1); chk("s1_bub_ctrl", oc1, 0);
    chk("s1_bub_data", od1, 0); chk("s1_bub_regs", og1, 0); chk("s1_bub_cnt0", bc1, 0);
    ordy1 = 1'b1;
    tick();
    chk("s1_bub_cnt1", bc1, 1); chk("s1_bub_gone", ov1, 0);

    // SKID=1 flush at TWO: bubble head delivered and counted, B and incoming beat discarded
    ordy1 = 1'b0;
    beat(16'h1111, 1'b1); v1 = 1'b1;
    tick();
    beat(16'h2222, 1'b0);
    tick();
    chk("s1_fl_two_r", r1, 0); chk("s1_fl_head_nop", on1, 1);
    beat(16'h3333, 1'b0); fl1 = 1'b1; ordy1 = 1'b1;
    tick();
    fl1 = 1'b0; v1 = 1'b0;
    chk("s1_fl_ov", ov1, 0); chk("s1_fl_r", r1, 1); chk("s1_fl_cnt", bc1, 2);
    tick();
    chk("s1_fl_after", ov1, 0);

    // SKID=1 flush at ONE drops a simultaneous accept
    ordy1 = 1'b0;
    beat(16'h4444, 1'b0); v1 = 1'b1;
    tick();
    beat(16'h5555, 1'b0); fl1 = 1'b1;
    tick();
    fl1 = 1'b0; v1 = 1'b0;
    chk("s1_fl1_ov", ov1, 0); chk("s1_fl1_r", r1, 1);
    tick();
    chk("s1_fl1_after", ov1, 0);

    // SKID=1 saturation from a forced count of FFFE
    force u_dut1.bubble_cnt_q = 16'hFFFE;
    tick();
    release u_dut1.bubble_cnt_q;
    tick();
    chk("s1_sat_pre", bc1, 16'hFFFE);
    ordy1 = 1'b1; beat(16'h0, 1'b1); v1 = 1'b1;
    tick();
    tick();
    chk("s1_sat_1", bc1, 16'hFFFF);
    tick();
    v1 = 1'b0;
    chk("s1_sat_2", bc1, 16'hFFFF);
    tick();
    chk("s1_sat_3", bc1, 16'hFFFF); chk("s1_sat_empty", ov1, 0);

    // SKID=0 stream
    ordy0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(16'(i + 16'h10), 1'b0); v0 = 1'b1;
      tick();
      chk("s0_str_ov", ov0, 1);
      chk("s0_str_od", od0, {16'(i + 16'h10) ^ 16'h5A5A, 16'(i + 16'h10)});
      chk("s0_str_r", r0, 1);
    end
    v0 = 1'b0;
    tick();
    chk("s0_str_end", ov0, 0);

    // SKID=0 backpressure with combinational ready
    ordy0 = 1'b0;
    beat(16'hAAAA, 1'b0); v0 = 1'b1;
    tick();
    chk("s0_bp_a", od0[15:0], 16'hAAAA); chk("s0_bp_r0", r0, 0);
    beat(16'hBBBB, 1'b0);
    tick();
    chk("s0_bp_hold", od0[15:0], 16'hAAAA);
    ordy0 = 1'b1;
    #1;
    chk("s0_bp_r_comb", r0, 1);
    tick();
    chk("s0_bp_b", od0[15:0], 16'hBBBB);
    v0 = 1'b0;
    tick();
    chk("s0_bp_empty", ov0, 0);

    // SKID=0 bubble
    ordy0 = 1'b0;
    v0 = 1'b1; in_nop = 1'b1; in_ctrl = 10'h3FF; in_data = 32'hFFFF_FFFF; in_regs = 16'hFFFF;
    tick();
    v0 = 1'b0; in_nop = 1'b0;
    chk("s0_bub_nop", on0, 1); chk("s0_bub_ctrl", oc0, 0); chk("s0_bub_data", od0, 0);
    chk("s0_bub_cnt0", bc0, 0);
    ordy0 = 1'b1;
    tick();
    chk("s0_bub_cnt1", bc0, 1); chk("s0_bub_gone", ov0, 0);

    // SKID=0 flush drops the beat accepted alongside the final deliver
    ordy0 = 1'b0;
    beat(16'h1111, 1'b0); v0 = 1'b1;
    tick();
    beat(16'h3333, 1'b0); fl0 = 1'b1; ordy0 = 1'b1;
    #1;
    chk("s0_fl_r_pre", r0, 1);
    tick();
    fl0 = 1'b0; v0 = 1'b0;
    chk("s0_fl_ov", ov0, 0); chk("s0_fl_r", r0, 1);
    tick();
    chk("s0_fl_after", ov0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
